// File: rtl/nbbpu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the NBBPU data bus.
// CPU stores to BASE_ADDR are queued in a byte FIFO and serialised LSB first on tx.
module nbbpu_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  // Bus handshake: a store is accepted on the rising edge where write_enable is
  // high, address hits BASE_ADDR and the FIFO is not full; there is no stall,
  // rejected stores are dropped and firmware polls STATUS for space.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;
  localparam logic [4:0]  DEPTH_CNT   = 5'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_done;
  logic          unused_hi;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == 5'd0);
  assign push      = write_enable && (address == BASE_ADDR) && !full;
  assign pop       = (state == IDLE) && !empty;
  assign baud_done = (baud == BAUD_LAST);
  assign unused_hi = ^write_data[15:8];

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    read_data = 16'h0000;
    if (address == STATUS_ADDR) begin
      read_data = {3'b000, count, 5'b00000, busy, empty, full};
    end
  end

  // Storage has no reset: pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // tx is registered and always updated together with the state that drives it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= mem[rd_ptr];
            baud  <= 16'd0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud  <= 16'd0;
            state <= IDLE;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= 16'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbbpu_uart_tx.sv
// Self-checking bench for nbbpu_uart_tx: a serial monitor decodes frames and
// compares them against a queue of bytes pushed when stores are driven.
module tb_nbbpu_uart_tx;

  localparam int C = 4;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [15:0] address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        tx;
  logic        busy;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  logic       mon_active = 1'b0;
  int         mon_cycle  = 0;
  logic [7:0] mon_byte   = 8'h00;
  int         frames_started = 0;
  int         frames_done    = 0;
  int         tx_low_cnt     = 0;

  nbbpu_uart_tx #(
    .BASE_ADDR   (16'hFF00),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .tx          (tx),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [15:0] status_word(input int cnt, input logic bsy);
    logic [4:0] c5;
    c5 = 5'(cnt);
    return {3'b000, c5, 5'b00000, bsy, (cnt == 0), (cnt == 8)};
  endfunction

  // Serial monitor: start bit sampled at C/2, data bits at their centres.
  initial begin
    forever begin
      @(negedge clock);
      if (tx === 1'b0) tx_low_cnt++;
      if (reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cycle  = 0;
          mon_byte   = 8'h00;
          frames_started++;
        end
      end else begin
        mon_cycle++;
        if (mon_cycle == C / 2) begin
          n_checks++;
          if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL start_bit: tx=%b required 0", tx);
          end
        end
        if (mon_cycle >= C + C / 2 && mon_cycle < 9 * C && ((mon_cycle - C / 2) % C) == 0) begin
          mon_byte[(mon_cycle - C / 2) / C - 1] = tx;
        end
        if (mon_cycle == 9 * C + C / 2) begin
          n_checks++;
          if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_bit: tx=%b required 1", tx);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got %02h, none required", mon_byte);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (mon_byte !== e) begin
              n_fail++;
              $display("FAIL frame_byte: got %02h required %02h", mon_byte, e);
            end
          end
          frames_done++;
        end
        if (mon_cycle == 10 * C - 1) mon_active = 1'b0;
      end
    end
  end

  // Driver: called at a negedge, returns at the following negedge.
  task automatic store(input logic [15:0] a, input logic [15:0] d, input bit accept);
    write_enable = 1'b1;
    address      = a;
    write_data   = d;
    if (accept) exp_q.push_back(d[7:0]);
    @(posedge clock);
    @(negedge clock);
    write_enable = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !mon_active && busy === 1'b0) break;
      @(negedge clock);
    end
    n_checks++;
    if (i >= limit) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes pending after %0d cycles", exp_q.size(), limit);
    end
  endtask

  task automatic check_status(input string name, input logic [15:0] req);
    address = 16'hFF01;
    #1;
    n_checks++;
    if (read_data !== req) begin
      n_fail++;
      $display("FAIL %s: status=%04h required %04h", name, read_data, req);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    write_enable = 1'b0;
    address      = 16'hFF01;
    write_data   = 16'h0000;
    repeat (3) @(negedge clock);
    check_status("reset_status_in_reset", 16'h0002);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lines: tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
    reset = 1'b0;
    @(negedge clock);
    check_status("reset_status", 16'h0002);
    address = 16'hFF00;
    #1;
    n_checks++;
    if (read_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL data_addr_read: got %04h required 0000", read_data);
    end
    address = 16'h1234;
    #1;
    n_checks++;
    if (read_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL other_addr_read: got %04h required 0000", read_data);
    end
    @(negedge clock);
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    int         wave_err;
    int         busy_cnt;
    logic       e;
    b = 8'hA5;
    store(16'hFF00, 16'h12A5, 1'b1);
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_before_pop: tx=%b required 1", tx);
    end
    wave_err = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10 * C; i++) begin
      @(negedge clock);
      #1;
      if (i < C) e = 1'b0;
      else if (i < 9 * C) e = b[i / C - 1];
      else e = 1'b1;
      if (tx !== e) wave_err++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (wave_err != 0) begin
      n_fail++;
      $display("FAIL frame_waveform: %0d wrong cycles required 0", wave_err);
    end
    n_checks++;
    if (busy_cnt != 10 * C) begin
      n_fail++;
      $display("FAIL busy_length: %0d cycles required %0d", busy_cnt, 10 * C);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL after_frame: busy=%b tx=%b required 0/1", busy, tx);
    end
    check_status("status_after_frame", 16'h0002);
    wait_done(50);
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 10; i++) begin
      store(16'hFF00, 16'(i), i < 9);
      if (i == 0) begin
        n_checks++;
        if (tx !== 1'b1) begin
          n_fail++;
          $display("FAIL first_push_tx: tx=%b required 1", tx);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL pop_on_edge2: tx=%b busy=%b required 0/1", tx, busy);
        end
      end
      if (i == 8) check_status("full_status", status_word(8, 1'b1));
    end
    check_status("full_after_drop", status_word(8, 1'b1));
    wait_done(1000);
    check_status("status_after_drain", 16'h0002);
  endtask

  task automatic test_other_addr();
    int lows;
    int frames;
    lows   = tx_low_cnt;
    frames = frames_started;
    store(16'hFF01, 16'h00FF, 1'b0);
    store(16'h0040, 16'h00FF, 1'b0);
    repeat (3 * C) @(negedge clock);
    n_checks++;
    if (tx_low_cnt != lows || frames_started != frames) begin
      n_fail++;
      $display("FAIL ignored_writes: tx low %0d cycles, %0d frames, required 0/0",
               tx_low_cnt - lows, frames_started - frames);
    end
    check_status("status_unchanged", 16'h0002);
  endtask

  task automatic test_back_to_back();
    int i;
    store(16'hFF00, 16'h0055, 1'b1);
    store(16'hFF00, 16'h000F, 1'b1);
    for (i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      @(negedge clock);
    end
    n_checks++;
    if (i >= 100 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_gap: busy=%b tx=%b after %0d cycles required 0/1", busy, tx, i);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      n_fail++;
      $display("FAIL second_start: busy=%b tx=%b required 1/0", busy, tx);
    end
    wait_done(200);
  endtask

  task automatic test_reset_mid_frame();
    int i;
    int frames;
    int lows;
    store(16'hFF00, 16'h0033, 1'b1);
    store(16'hFF00, 16'h00C4, 1'b1);
    store(16'hFF00, 16'h0081, 1'b1);
    // bit 3 occupies monitor cycles 4C..5C-1
    for (i = 0; i < 200; i++) begin
      if (mon_active && mon_cycle == 4 * C + 1) break;
      @(negedge clock);
    end
    n_checks++;
    if (i >= 200) begin
      n_fail++;
      $display("FAIL reach_bit3: not reached in %0d cycles", i);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: tx=%b busy=%b required 1/0", tx, busy);
    end
    exp_q.delete();
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    frames = frames_started;
    lows   = tx_low_cnt;
    check_status("status_after_reset", 16'h0002);
    repeat (15 * C) @(negedge clock);
    n_checks++;
    if (frames_started != frames || tx_low_cnt != lows) begin
      n_fail++;
      $display("FAIL no_frames_after_reset: %0d frames, %0d low cycles, required 0/0",
               frames_started - frames, tx_low_cnt - lows);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fifo_full();
    test_other_addr();
    test_back_to_back();
    test_reset_mid_frame();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_bytes: %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
